// File: rtl/intersection_pkg.sv
// Shared types for the intersection phase scheduler: light encodings, FSM states, phase index.
// Pure declarations plus a helper that places one phase's light into the packed light vector.
package intersection_pkg;

    localparam int NUM_PHASES = 4;

    typedef logic [1:0] phase_idx_t;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b11
    } light_t;

    typedef enum logic [1:0] {
        S_GREEN,
        S_YELLOW,
        S_ALL_RED
    } sched_state_t;

    // All phases RED except phase p, which shows light l.
    function automatic logic [2*NUM_PHASES-1:0] light_vec(input phase_idx_t p, input light_t l);
        logic [2*NUM_PHASES-1:0] v;
        v = '0;
        v[2*int'(p) +: 2] = l;
        return v;
    endfunction

endpackage

// File: rtl/rr_phase_picker.sv
// Round-robin phase picker: first pending phase at or after start, wrapping around.
// Purely combinational, zero latency, no flow control.
module rr_phase_picker
    import intersection_pkg::*;
(
    input  logic [NUM_PHASES-1:0] req,
    input  phase_idx_t            start,
    output logic                  vld,
    output phase_idx_t            phase
);

    phase_idx_t idx;

    // Scan farthest-first so the nearest pending phase is the last write and wins.
    always_comb begin
        vld   = 1'b0;
        phase = '0;
        idx   = '0;
        for (int k = NUM_PHASES - 1; k >= 0; k--) begin
            idx = start + phase_idx_t'(k);
            if (req[idx]) begin
                vld   = 1'b1;
                phase = idx;
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Four-phase green/yellow/all-red scheduler with demand latching, extension timing and preempt.
// All outputs registered; lights follow the state on the edge it changes, no backpressure.
module intersection_phase_scheduler
    import intersection_pkg::*;
#(
    parameter int MIN_GREEN_TIME = 10,
    parameter int MAX_GREEN_TIME = 40,
    parameter int EXTENSION_TIME = 3,
    parameter int YELLOW_TIME    = 4,
    parameter int ALL_RED_TIME   = 2,
    parameter int TIMER_WIDTH    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] phase_req,
    input  logic       preempt_req,
    input  logic [1:0] preempt_phase,
    output logic [7:0] phase_light,
    output logic [1:0] active_phase,
    output logic [3:0] req_pending,
    output logic       preempt_active
);

    localparam logic [TIMER_WIDTH-1:0] MIN_G     = TIMER_WIDTH'(MIN_GREEN_TIME);
    localparam logic [TIMER_WIDTH-1:0] MAX_G     = TIMER_WIDTH'(MAX_GREEN_TIME);
    localparam logic [TIMER_WIDTH-1:0] EXT_LOAD  = TIMER_WIDTH'(EXTENSION_TIME);
    localparam logic [TIMER_WIDTH-1:0] YEL_LAST  = TIMER_WIDTH'(YELLOW_TIME - 1);
    localparam logic [TIMER_WIDTH-1:0] ARED_LAST = TIMER_WIDTH'(ALL_RED_TIME - 1);

    sched_state_t           state_q, state_d;
    phase_idx_t             active_q, active_d;
    logic [TIMER_WIDTH-1:0] green_cnt_q, ext_cnt_q, clr_cnt_q;
    logic [3:0]             pend_q, active_oh, set_mask, clr_mask;
    logic                   other, exit_green, enter_green, pick_vld;
    phase_idx_t             pick_phase;
    light_t                 light_d;

    rr_phase_picker u_picker (
        .req   (pend_q),
        .start (active_q + phase_idx_t'(1)),
        .vld   (pick_vld),
        .phase (pick_phase)
    );

    always_comb begin
        active_oh   = 4'b0001 << active_q;
        other       = |(pend_q & ~active_oh);
        state_d     = state_q;
        active_d    = active_q;
        exit_green  = 1'b0;
        enter_green = 1'b0;
        unique case (state_q)
            S_GREEN: begin
                // A preempt for the active phase pins green; any other preempt skips min green.
                if (preempt_req)
                    exit_green = (preempt_phase != active_q);
                else
                    exit_green = other && ((green_cnt_q >= MAX_G) ||
                                           ((green_cnt_q >= MIN_G) && (ext_cnt_q == '0)));
                if (exit_green)
                    state_d = S_YELLOW;
            end
            S_YELLOW: begin
                if (clr_cnt_q == YEL_LAST)
                    state_d = S_ALL_RED;
            end
            S_ALL_RED: begin
                if (clr_cnt_q == ARED_LAST) begin
                    state_d     = S_GREEN;
                    enter_green = 1'b1;
                    if (preempt_req)
                        active_d = preempt_phase;
                    else if (pick_vld)
                        active_d = pick_phase;
                    else
                        active_d = '0;
                end
            end
            default: state_d = S_GREEN;
        endcase

        // Demand on the green phase feeds the extension timer instead of the latch.
        set_mask = phase_req & ~((state_q == S_GREEN) ? active_oh : 4'b0000);
        clr_mask = enter_green ? (4'b0001 << active_d) : 4'b0000;
        light_d  = (state_d == S_GREEN)  ? GREEN :
                   (state_d == S_YELLOW) ? YELLOW : RED;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_GREEN;
            active_q       <= '0;
            green_cnt_q    <= '0;
            ext_cnt_q      <= '0;
            clr_cnt_q      <= '0;
            pend_q         <= '0;
            phase_light    <= light_vec(phase_idx_t'(0), GREEN);
            preempt_active <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            pend_q   <= (pend_q | set_mask) & ~clr_mask;

            if (state_q == S_GREEN && state_d == S_GREEN) begin
                if (green_cnt_q != '1)
                    green_cnt_q <= green_cnt_q + TIMER_WIDTH'(1);
                if (phase_req[active_q])
                    ext_cnt_q <= EXT_LOAD;
                else if (ext_cnt_q != '0)
                    ext_cnt_q <= ext_cnt_q - TIMER_WIDTH'(1);
            end else begin
                green_cnt_q <= '0;
                ext_cnt_q   <= '0;
            end

            if (state_d != state_q)
                clr_cnt_q <= '0;
            else if (state_q != S_GREEN)
                clr_cnt_q <= clr_cnt_q + TIMER_WIDTH'(1);

            phase_light    <= light_vec(active_d, light_d);
            preempt_active <= (state_d == S_GREEN) && preempt_req && (preempt_phase == active_d);
        end
    end

    assign active_phase = active_q;
    assign req_pending  = pend_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler: directed vector table, multi-cycle sequences,
// and randomized traffic against a phase-level reference model.
module tb_intersection_phase_scheduler;

    localparam int MIN_G = 10;
    localparam int MAX_G = 40;
    localparam int EXT   = 3;
    localparam int YEL   = 4;
    localparam int ARED  = 2;

    logic       clk;
    logic       reset_n;
    logic [3:0] phase_req;
    logic       preempt_req;
    logic [1:0] preempt_phase;
    logic [7:0] phase_light;
    logic [1:0] active_phase;
    logic [3:0] req_pending;
    logic       preempt_active;

    int n_cmp  = 0;
    int n_fail = 0;

    intersection_phase_scheduler dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .phase_req      (phase_req),
        .preempt_req    (preempt_req),
        .preempt_phase  (preempt_phase),
        .phase_light    (phase_light),
        .active_phase   (active_phase),
        .req_pending    (req_pending),
        .preempt_active (preempt_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: mode 0=green 1=yellow 2=all-red, m_t = cycles spent in current mode.
    int         m_mode, m_phase, m_gc, m_ext, m_t;
    logic [3:0] m_pend;
    logic       m_pact;

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_gc = 0; m_ext = 0; m_t = 1;
        m_pend = '0; m_pact = 1'b0;
    endtask

    function automatic logic [7:0] model_light();
        logic [7:0] v;
        v = '0;
        if (m_mode == 0) v[2*m_phase +: 2] = 2'b11;
        else if (m_mode == 1) v[2*m_phase +: 2] = 2'b01;
        return v;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic p, input logic [1:0] pp);
        int  nmode, nphase;
        bit  other, found;
        nmode = m_mode; nphase = m_phase; other = 0; found = 0;
        for (int i = 0; i < 4; i++)
            if (i != m_phase && m_pend[i]) other = 1;
        if (m_mode == 0) begin
            if (p && int'(pp) != m_phase) nmode = 1;
            else if (!p && other && (m_gc >= MAX_G || (m_gc >= MIN_G && m_ext == 0))) nmode = 1;
        end else if (m_mode == 1) begin
            if (m_t == YEL) nmode = 2;
        end else if (m_t == ARED) begin
            nmode = 0;
            if (p) nphase = int'(pp);
            else begin
                nphase = 0;
                for (int k = 1; k <= 4; k++)
                    if (!found && m_pend[(m_phase + k) % 4]) begin
                        found = 1;
                        nphase = (m_phase + k) % 4;
                    end
            end
        end
        for (int i = 0; i < 4; i++)
            if (r[i] && !(m_mode == 0 && i == m_phase)) m_pend[i] = 1'b1;
        if (m_mode == 2 && nmode == 0) m_pend[nphase] = 1'b0;
        if (m_mode == 0 && nmode == 0) begin
            m_gc  = (m_gc < 255) ? m_gc + 1 : 255;
            m_ext = r[m_phase] ? EXT : ((m_ext > 0) ? m_ext - 1 : 0);
        end else begin
            m_gc = 0; m_ext = 0;
        end
        m_t     = (nmode == m_mode) ? m_t + 1 : 1;
        m_mode  = nmode;
        m_phase = nphase;
        m_pact  = (nmode == 0) && p && (int'(pp) == nphase);
    endtask

    function automatic logic [14:0] obs();
        return {phase_light, active_phase, req_pending, preempt_active};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic p, input logic [1:0] pp);
        phase_req = r; preempt_req = p; preempt_phase = pp;
        @(posedge clk);
        model_step(r, p, pp);
        #1;
    endtask

    task automatic do_reset();
        phase_req = '0; preempt_req = 1'b0; preempt_phase = '0;
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_light(input string name, input logic [7:0] target, input int bound);
        int n;
        n = 0;
        while (phase_light !== target && n < bound) begin
            step(4'b0000, 1'b0, 2'd0);
            n++;
        end
        chk(name, phase_light, target);
    endtask

    task automatic count_until_change(input logic [3:0] r, output int n);
        logic [7:0] start;
        start = phase_light;
        n = 0;
        do begin
            step(r, 1'b0, 2'd0);
            n++;
        end while (phase_light === start && n < 200);
    endtask

    // Green -> yellow -> all-red -> next green.
    task automatic next_green();
        int n;
        for (int s = 0; s < 3; s++) count_until_change(4'b0000, n);
    endtask

    typedef struct {
        bit          rst;
        int          n;
        logic [3:0]  req;
        logic        pre;
        logic [1:0]  pp;
        logic [14:0] exp;
    } vec_t;

    function automatic vec_t mk(bit rst, int n, logic [3:0] req, logic pre, logic [1:0] pp,
                                logic [7:0] light, logic [1:0] act, logic [3:0] pend, logic pact);
        vec_t v;
        v.rst = rst; v.n = n; v.req = req; v.pre = pre; v.pp = pp;
        v.exp = {light, act, pend, pact};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int n;
        int nonred;
        logic       rp;
        logic [1:0] rpp;
        logic [3:0] rr;

        reset_n = 1'b0;
        phase_req = '0; preempt_req = 1'b0; preempt_phase = '0;
        model_reset();

        // Idle rest, then phase 2 served after a pulse; then preempt to phase 3 and release.
        tbl.push_back(mk(1, 100, 4'h0, 0, 0, 8'h03, 0, 4'h0, 0));
        tbl.push_back(mk(1,   3, 4'h0, 0, 0, 8'h03, 0, 4'h0, 0));
        tbl.push_back(mk(0,   1, 4'h4, 0, 0, 8'h03, 0, 4'h4, 0));
        tbl.push_back(mk(0,   6, 4'h0, 0, 0, 8'h03, 0, 4'h4, 0));
        tbl.push_back(mk(0,   1, 4'h0, 0, 0, 8'h01, 0, 4'h4, 0));
        tbl.push_back(mk(0,   3, 4'h0, 0, 0, 8'h01, 0, 4'h4, 0));
        tbl.push_back(mk(0,   1, 4'h0, 0, 0, 8'h00, 0, 4'h4, 0));
        tbl.push_back(mk(0,   1, 4'h0, 0, 0, 8'h00, 0, 4'h4, 0));
        tbl.push_back(mk(0,   1, 4'h0, 0, 0, 8'h30, 2, 4'h0, 0));
        tbl.push_back(mk(1,   2, 4'h0, 0, 0, 8'h03, 0, 4'h0, 0));
        tbl.push_back(mk(0,   1, 4'h0, 1, 3, 8'h01, 0, 4'h0, 0));
        tbl.push_back(mk(0,   4, 4'h0, 1, 3, 8'h00, 0, 4'h0, 0));
        tbl.push_back(mk(0,   1, 4'h0, 1, 3, 8'h00, 0, 4'h0, 0));
        tbl.push_back(mk(0,   1, 4'h0, 1, 3, 8'hC0, 3, 4'h0, 1));
        tbl.push_back(mk(0,  20, 4'h2, 1, 3, 8'hC0, 3, 4'h2, 1));
        tbl.push_back(mk(0,   1, 4'h0, 0, 3, 8'h40, 3, 4'h2, 0));
        tbl.push_back(mk(0,   6, 4'h0, 0, 0, 8'h0C, 1, 4'h0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            if (i == 0) chk("reset_state", obs(), 15'h0180);
            for (int c = 0; c < tbl[i].n; c++) step(tbl[i].req, tbl[i].pre, tbl[i].pp);
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // Held demand on the green phase: forced out at max green (count 0..40).
        do_reset();
        step(4'b0100, 1'b0, 2'd0);
        wait_light("maxg_enter", 8'h30, 60);
        count_until_change(4'b0101, n);
        chk("maxg_len", n, 41);
        chk("maxg_yellow", phase_light, 8'h10);

        // Single extension pulse at count 9: exit at count 13.
        do_reset();
        step(4'b0100, 1'b0, 2'd0);
        wait_light("ext_enter", 8'h30, 60);
        step(4'b0001, 1'b0, 2'd0);
        repeat (8) step(4'b0000, 1'b0, 2'd0);
        step(4'b0100, 1'b0, 2'd0);
        count_until_change(4'b0000, n);
        chk("ext_tail", n, 4);
        chk("ext_yellow", obs(), {8'h10, 2'd2, 4'h1, 1'b0});

        // Round-robin order from phase 2 with 1 and 3 pending: 3, then 1, then rest.
        do_reset();
        step(4'b0100, 1'b0, 2'd0);
        wait_light("rr_enter", 8'h30, 60);
        step(4'b1010, 1'b0, 2'd0);
        next_green();
        chk("rr_first", obs(), {8'hC0, 2'd3, 4'h2, 1'b0});
        next_green();
        chk("rr_second", obs(), {8'h0C, 2'd1, 4'h0, 1'b0});
        repeat (100) step(4'b0000, 1'b0, 2'd0);
        chk("rr_rest", obs(), {8'h0C, 2'd1, 4'h0, 1'b0});

        // Reset mid-yellow acts without a clock edge and drops latched demand.
        do_reset();
        step(4'b0100, 1'b0, 2'd0);
        wait_light("arst_yellow", 8'h01, 60);
        step(4'b0010, 1'b0, 2'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_async", obs(), 15'h0180);

        // Randomized traffic against the reference model.
        do_reset();
        rp = 1'b0; rpp = 2'd0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 63) == 0) begin
                rp  = ~rp;
                rpp = 2'($urandom_range(0, 3));
            end
            rr = '0;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 19) == 0) rr[b] = 1'b1;
            if ($urandom_range(0, 3) == 0) rr[active_phase] = 1'b1;
            step(rr, rp, rpp);
            chk($sformatf("model_c%0d", c), obs(),
                {model_light(), 2'(m_phase), m_pend, m_pact});
            nonred = 0;
            for (int b = 0; b < 4; b++)
                if (phase_light[2*b +: 2] != 2'b00) nonred++;
            chk($sformatf("one_lit_c%0d", c), (nonred <= 1) ? 1 : 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Four-phase intersection scheduler that shares right-of-way among four approach phases: main road, side road, pedestrian walk and main left-turn. It latches per-phase demand, grants green to one phase at a time in round-robin order under min/max/extension timing, and inserts yellow and all-red clearance between phases. An emergency preempt input overrides normal arbitration. Each phase drives the same 2-bit light encoding used by the existing light controller.

## Interface
- MIN_GREEN_TIME, 10, minimum green cycles before a phase may be pre-empted by normal demand
- MAX_GREEN_TIME, 40, hard green limit while other demand is pending; must be > MIN_GREEN_TIME
- EXTENSION_TIME, 3, gap timer reloaded by demand on the active phase
- YELLOW_TIME, 4, yellow cycles (≥1)
- ALL_RED_TIME, 2, all-red cycles (≥1)
- TIMER_WIDTH, 8, counter width; all times < 2**TIMER_WIDTH
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- phase_req  input  4  per-phase demand (pulse or level), bit i = phase i
- preempt_req  input  1  emergency preempt, level
- preempt_phase  input  2  phase to serve under preempt
- phase_light  output  8  bits [2i+1:2i] = light of phase i: RED 2'b00, YELLOW 2'b01, GREEN 2'b11
- active_phase  output  2  phase currently or most recently green
- req_pending  output  4  latched demand
- preempt_active  output  1  preempt phase is green and preempt_req is high

## Operation
- Reset: state S_GREEN, active_phase=0, phase_light=8'b00_00_00_11, req_pending=0, preempt_active=0, green_cnt=0, ext_cnt=0.
- Demand latch: req_pending[i] set when phase_req[i]=1 at a clock edge, except phase_req[active_phase] while in S_GREEN (drives extension instead). Cleared on the edge phase i enters S_GREEN; a same-edge set for that phase is dropped.
- S_GREEN: green_cnt increments from 0 at entry (saturates). ext_cnt loads EXTENSION_TIME when phase_req[active_phase]=1, else decrements to 0. other = |(req_pending & ~onehot(active_phase)).
  - Exit to S_YELLOW when other && (green_cnt ≥ MAX_GREEN_TIME || (green_cnt ≥ MIN_GREEN_TIME && ext_cnt==0)).
  - Exit immediately (ignoring min green) when preempt_req && preempt_phase != active_phase.
  - While preempt_req && preempt_phase == active_phase: no exit; preempt_active=1.
  - No other demand and no preempt: rest on green indefinitely.
- S_YELLOW: active phase YELLOW for YELLOW_TIME cycles, then S_ALL_RED. Never shortened by preempt.
- S_ALL_RED: all phases RED for ALL_RED_TIME cycles. On the last cycle select next phase: preempt_phase if preempt_req, else first pending phase in round-robin order starting at active_phase+1, else phase 0. Enter S_GREEN, update active_phase, reset green_cnt and ext_cnt.
- Preempt deassert while green: normal exit rules resume using the existing green_cnt.
- Invariant: at most one phase non-RED at any cycle; never GREEN→GREEN without YELLOW and ALL_RED.

## Timing
- All outputs registered; phase_light changes on the edge the state changes.
- phase_req pulse sampled at edge n → req_pending visible after edge n.
- Exit condition true at edge n → YELLOW visible after edge n; GREEN of next phase visible exactly YELLOW_TIME+ALL_RED_TIME cycles later.
- With a request pending from green entry, green lasts exactly MIN_GREEN_TIME+1 cycles (count 0..MIN_GREEN_TIME).
- Demand arriving during S_YELLOW/S_ALL_RED is included in the selection on the final all-red cycle.
- reset_n low at any time forces reset values asynchronously; latched demand is lost.

## Structure
- intersection_pkg: light_t enum (RED, YELLOW, GREEN with the encodings above), sched_state_t {S_GREEN, S_YELLOW, S_ALL_RED}, phase_idx_t (2-bit), NUM_PHASES=4.
- Sub-module rr_phase_picker: combinational round-robin selector (req_pending, start index) → {valid, phase}.

## Test plan
- Reset, no demand for 100 cycles → phase_light stays 8'b00_00_00_11, active_phase=0.
- Pulse phase_req[2] 3 cycles after reset → phase 0 green until green_cnt=10, YELLOW 4 cycles, all RED 2 cycles, then phase_light=8'b00_11_00_00, req_pending[2] cleared.
- Phase 2 green with phase 0 pending, phase_req[2] held high continuously → exit forced at green_cnt=40; one pulse at green_cnt=9 instead → exit at green_cnt=13 (ext_cnt expiry).
- Phases 1, 2, 3 pending simultaneously while phase 2 green → served in order 3, 0-skip (not pending), 1, then rest on 1.
- preempt_req=1, preempt_phase=3 at green_cnt=2 of phase 0 with no other demand → immediate YELLOW, clearance, phase 3 GREEN with preempt_active=1, holds despite phase_req[1] until preempt drops, then MIN rules exit to phase 1.
- Assert reset_n=0 mid-YELLOW → outputs return to reset values without waiting for a clock edge.
